// File: rtl/fpga_robots_game_keys_pkg.sv
// Shared constants for the robots-game keyboard front end: command bit indices,
// PS/2 set-2 prefix scancodes and the prefix-decoder state encoding.
package fpga_robots_game_keys_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned KEY_ID_W = 9;

  localparam int unsigned CMDB_NEWGAME  = 0;
  localparam int unsigned CMDB_DUMP     = 1;
  localparam int unsigned CMDB_TELEPORT = 2;
  localparam int unsigned CMDB_WAIT     = 3;
  localparam int unsigned CMDB_N        = 4;
  localparam int unsigned CMDB_NE       = 5;
  localparam int unsigned CMDB_E        = 6;
  localparam int unsigned CMDB_SE       = 7;
  localparam int unsigned CMDB_S        = 8;
  localparam int unsigned CMDB_SW       = 9;
  localparam int unsigned CMDB_W        = 10;
  localparam int unsigned CMDB_NW       = 11;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT    = 3'd1,
    S_BRK    = 3'd2,
    S_EXTBRK = 3'd3,
    S_SKIP   = 3'd4
  } ps2_state_e;

  function automatic logic [CMD_W-1:0] cmd_bit(input int unsigned idx);
    cmd_bit = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/fpga_robots_game_keys_if.sv
// Byte stream from the PS/2 receiver into the key decoder.
interface fpga_robots_game_keys_if;
  logic [7:0] ps2_byte;
  logic       ps2_stb;
  logic       ps2_err;

  modport master (output ps2_byte, output ps2_stb, output ps2_err);
  modport slave  (input  ps2_byte, input  ps2_stb, input  ps2_err);
endinterface

// File: rtl/fpga_robots_game_keys_keymap.sv
// Combinational {ext, code} -> one-hot command mask; zero means the key is unmapped.
module fpga_robots_game_keys_keymap
  import fpga_robots_game_keys_pkg::*;
(
  input  logic [KEY_ID_W-1:0] key_id_i,
  output logic [CMD_W-1:0]    mask_o
);

  // Key table; keypad arrows also accept their E0-prefixed cursor-key twins
  always_comb begin
    mask_o = 16'h0000;
    case (key_id_i)
      9'h006:         mask_o = cmd_bit(CMDB_NEWGAME);
      9'h007:         mask_o = cmd_bit(CMDB_DUMP);
      9'h02C:         mask_o = cmd_bit(CMDB_TELEPORT);
      9'h073:         mask_o = cmd_bit(CMDB_WAIT);
      9'h075, 9'h175: mask_o = cmd_bit(CMDB_N);
      9'h07D:         mask_o = cmd_bit(CMDB_NE);
      9'h074, 9'h174: mask_o = cmd_bit(CMDB_E);
      9'h07A:         mask_o = cmd_bit(CMDB_SE);
      9'h072, 9'h172: mask_o = cmd_bit(CMDB_S);
      9'h069:         mask_o = cmd_bit(CMDB_SW);
      9'h06B, 9'h16B: mask_o = cmd_bit(CMDB_W);
      9'h06C:         mask_o = cmd_bit(CMDB_NW);
      default:        mask_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/fpga_robots_game_keys.sv
// PS/2 set-2 byte stream -> one-cycle one-hot game commands with repeat suppression.
// Build option FPGA_ROBOTS_GAME_KEY_AUTOREPEAT_EN lets typematic repeats pulse too.
module fpga_robots_game_keys
  import fpga_robots_game_keys_pkg::*;
#(
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  fpga_robots_game_keys_if.slave   ps2_if,
  output logic [CMD_W-1:0]         cmd_o,
  output logic                     dbg_o
);

  localparam int unsigned CNT_W = $clog2(PAUSE_SKIP + 1);

  ps2_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [KEY_ID_W-1:0] held_id_q, held_id_d;
  logic                held_vld_q, held_vld_d;

  logic                key_ext_s;
  logic [KEY_ID_W-1:0] key_id_s;
  logic [CMD_W-1:0]    key_mask_s;
  logic                make_s;
  logic                brk_s;
  logic                repeat_s;

  assign key_ext_s = (state_q == S_EXT) || (state_q == S_EXTBRK);
  assign key_id_s  = {key_ext_s, ps2_if.ps2_byte};

  fpga_robots_game_keys_keymap u_keymap (
    .key_id_i (key_id_s),
    .mask_o   (key_mask_s)
  );

`ifdef FPGA_ROBOTS_GAME_KEY_AUTOREPEAT_EN
  assign repeat_s = 1'b0;
`else
  assign repeat_s = held_vld_q && (held_id_q == key_id_s);
`endif

  // Prefix decoder: tracks E0/F0/E1 and flags the final byte as make or break
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    if (ps2_if.ps2_err) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (ps2_if.ps2_stb) begin
      case (state_q)
        S_IDLE, S_EXT: begin
          if (ps2_if.ps2_byte == SC_E0) begin
            state_d = S_EXT;
          end else if (ps2_if.ps2_byte == SC_F0) begin
            state_d = (state_q == S_EXT) ? S_EXTBRK : S_BRK;
          end else if (ps2_if.ps2_byte == SC_E1) begin
            state_d = S_SKIP;
            cnt_d   = CNT_W'(PAUSE_SKIP);
          end else begin
            state_d = S_IDLE;
            make_s  = 1'b1;
          end
        end
        S_BRK, S_EXTBRK: begin
          if (ps2_if.ps2_byte == SC_E0) begin
            state_d = S_EXT;
          end else if (ps2_if.ps2_byte == SC_F0) begin
            state_d = state_q;
          end else begin
            state_d = S_IDLE;
            brk_s   = 1'b1;
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SKIP;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Held-key tracking and command pulse generation
  always_comb begin
    cmd_d      = 16'h0000;
    held_id_d  = held_id_q;
    held_vld_d = held_vld_q;
    if (ps2_if.ps2_err) begin
      held_vld_d = 1'b0;
    end else if (make_s && (key_mask_s != 16'h0000)) begin
      if (repeat_s) begin
        cmd_d = 16'h0000;
      end else begin
        cmd_d = key_mask_s;
      end
      held_id_d  = key_id_s;
      held_vld_d = 1'b1;
    end else if (brk_s && held_vld_q && (held_id_q == key_id_s)) begin
      held_vld_d = 1'b0;
    end else begin
      held_vld_d = held_vld_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= 16'h0000;
      held_id_q  <= 9'h000;
      held_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      held_id_q  <= held_id_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign cmd_o = cmd_q;
  assign dbg_o = held_vld_q;

endmodule

// File: tb/tb_fpga_robots_game_keys.sv
// Randomised bench for fpga_robots_game_keys against a prefix-flag/key-table model,
// plus directed scenarios with literal expectations.
module tb_fpga_robots_game_keys;

`ifdef FPGA_ROBOTS_GAME_KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif
  localparam int PAUSE_SKIP = 7;

  logic        clk;
  logic        rst;
  logic [15:0] cmd;
  logic        dbg;

  fpga_robots_game_keys_if ps2 ();

  fpga_robots_game_keys #(.PAUSE_SKIP(PAUSE_SKIP)) dut (
    .clk    (clk),
    .rst    (rst),
    .ps2_if (ps2),
    .cmd_o  (cmd),
    .dbg_o  (dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  // model state
  int  km[int];
  bit  m_ext, m_brk;
  int  m_skip;
  bit  m_held;
  int  m_held_id;
  logic [15:0] nxt_cmd, exp_cmd;
  logic        exp_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_held = 0; m_held_id = 0;
    nxt_cmd = 16'h0000; exp_cmd = 16'h0000; exp_dbg = 1'b0;
  endtask

  task automatic model_step(input logic stb, input logic err, input logic [7:0] b);
    int id;
    if (err) begin
      m_ext = 0; m_brk = 0; m_skip = 0; m_held = 0;
    end else if (stb) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE1 && !m_brk) begin
        m_skip = PAUSE_SKIP; m_ext = 0;
      end else begin
        id = (m_ext ? 256 : 0) + int'(b);
        if (m_brk) begin
          if (m_held && m_held_id == id) m_held = 0;
        end else if (km.exists(id)) begin
          if (AUTOREP || !(m_held && m_held_id == id)) nxt_cmd = 16'h0001 << km[id];
          m_held = 1; m_held_id = id;
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic cyc(input logic stb, input logic err, input logic [7:0] b);
    @(posedge clk); #2;
    ps2.ps2_stb = stb; ps2.ps2_err = err; ps2.ps2_byte = b;
    model_step(stb, err, b);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, 1'b0, b);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  // expectation advance: registered outputs reflect the previous cycle's inputs
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        exp_cmd = nxt_cmd;
        exp_dbg = m_held;
      end
      nxt_cmd = 16'h0000;
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmd", cmd, exp_cmd);
        chk("dbg", {15'd0, dbg}, {15'd0, exp_dbg});
        chk("onehot", {15'd0, ($countones(cmd) > 1)}, 16'h0000);
        if (cmd != 16'h0000) pulse_cnt++;
      end
    end
  end

  initial begin
    logic [7:0] codes [0:15];
    logic [7:0] t4 [0:7];
    codes = '{8'h06, 8'h07, 8'h2C, 8'h73, 8'h75, 8'h7D, 8'h74, 8'h7A,
              8'h72, 8'h69, 8'h6B, 8'h6C, 8'h14, 8'hAA, 8'hFA, 8'hFE};
    t4 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    km[32'h006] = 0;  km[32'h007] = 1;  km[32'h02C] = 2;  km[32'h073] = 3;
    km[32'h075] = 4;  km[32'h175] = 4;  km[32'h07D] = 5;  km[32'h074] = 6;
    km[32'h174] = 6;  km[32'h07A] = 7;  km[32'h072] = 8;  km[32'h172] = 8;
    km[32'h069] = 9;  km[32'h06B] = 10; km[32'h16B] = 10; km[32'h06C] = 11;

    ps2.ps2_stb = 1'b0; ps2.ps2_err = 1'b0; ps2.ps2_byte = 8'h00;
    rst = 1'b1;
    model_reset();
    #23;
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_dbg", {15'd0, dbg}, 16'h0000);
    @(posedge clk); #2; rst = 1'b0;
    chk_en = 1'b1;

    // 1: F2 make
    send(8'h06); idle(); @(negedge clk);
    chk("t1_cmd", cmd, 16'h0001);
    chk("t1_dbg", {15'd0, dbg}, 16'h0001);

    // 2: E0 75 twice then extended break
    pulse_cnt = 0;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); idle(); idle(); @(negedge clk);
    chk("t2_pulses", 16'(pulse_cnt), AUTOREP ? 16'd2 : 16'd1);
    chk("t2_dbg", {15'd0, dbg}, 16'h0000);

    // 3: KP7 then Home (unmapped)
    send(8'h6C); idle(); @(negedge clk);
    chk("t3_cmd", cmd, 16'h0800);
    pulse_cnt = 0;
    send(8'hF0); send(8'h6C); send(8'hE0); send(8'h6C); idle(); idle(); @(negedge clk);
    chk("t3_home", 16'(pulse_cnt), 16'd0);

    // 4: Pause sequence swallowed, then T
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) send(t4[i]);
    idle(); idle(); @(negedge clk);
    chk("t4_pause", 16'(pulse_cnt), 16'd0);
    send(8'h2C); idle(); @(negedge clk);
    chk("t4_cmd", cmd, 16'h0004);

    // 5: error discards E0 prefix; error beats a same-cycle strobe
    send(8'hE0); cyc(1'b0, 1'b1, 8'h00); send(8'h74); idle(); @(negedge clk);
    chk("t5_cmd", cmd, 16'h0040);
    pulse_cnt = 0;
    cyc(1'b1, 1'b1, 8'h73); idle(); idle(); @(negedge clk);
    chk("t5_errstb", 16'(pulse_cnt), 16'd0);

    // 6: switch held key, repeat, foreign break, async reset mid-prefix
    pulse_cnt = 0;
    send(8'h74); send(8'h6B); send(8'h6B); send(8'hF0); send(8'h74);
    idle(); idle(); @(negedge clk);
    chk("t6_pulses", 16'(pulse_cnt), AUTOREP ? 16'd3 : 16'd2);
    chk("t6_dbg", {15'd0, dbg}, 16'h0001);
    send(8'h73); send(8'hE0);
    chk("t6_pre_rst", cmd, 16'h0008);
    #1; rst = 1'b1; model_reset();
    #1;
    chk("t6_rst_cmd", cmd, 16'h0000);
    chk("t6_rst_dbg", {15'd0, dbg}, 16'h0000);
    @(posedge clk); #2;
    ps2.ps2_stb = 1'b0; ps2.ps2_err = 1'b0; rst = 1'b0;
    send(8'h74); idle(); @(negedge clk);
    chk("t6_after_rst", cmd, 16'h0040);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int r, s;
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 99);
      if (r < 3) begin
        cyc(1'($urandom), 1'b1, 8'($urandom));
      end else if (r < 40) begin
        idle();
      end else if (s < 12) begin
        send(8'hE0);
      end else if (s < 22) begin
        send(8'hF0);
      end else if (s < 24) begin
        send(8'hE1);
      end else if (s < 80) begin
        send(codes[$urandom_range(0, 15)]);
      end else begin
        send(8'($urandom));
      end
    end
    idle(); idle(); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
